// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared state encoding for the ramped fan speed controller
package fan_ctrl_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ACTIVE   = 3'd1,
    ST_DWELL    = 3'd2,
    ST_OVERRIDE = 3'd3,
    ST_FAULT    = 3'd4
  } fan_state_t;
endpackage

// File: rtl/fan_level_map.sv
// fan_level_map: maps a temperature error to a fan speed level, saturating at full speed
module fan_level_map #(
  parameter int TEMP_W  = 7,
  parameter int SPEED_W = 2,
  parameter int STEP    = 5
) (
  input  logic [TEMP_W:0]    delta,
  output logic [SPEED_W-1:0] level
);
  localparam logic [TEMP_W:0]   STEP_V  = (TEMP_W+1)'(STEP);
  localparam logic [TEMP_W+1:0] MAX_SPD = (TEMP_W+2)'((1 << SPEED_W) - 1);
  logic [TEMP_W+1:0] raw;
  // one level per STEP degrees of error, the first level starting at one degree
  always_comb begin
    raw   = {1'b0, delta / STEP_V} + (TEMP_W+2)'(1);
    level = (delta == '0) ? '0 : (raw >= MAX_SPD) ? '1 : raw[SPEED_W-1:0];
  end
endmodule

// File: rtl/ramped_fan_speed_controller.sv
// ramped_fan_speed_controller: one-level-at-a-time fan ramp with dwell, manual override and sensor watchdog
module ramped_fan_speed_controller
  import fan_ctrl_pkg::*;
#(
  parameter int TEMP_W      = 7,
  parameter int SPEED_W     = 2,
  parameter int STEP        = 5,
  parameter int HYST        = 2,
  parameter int DWELL_CYC   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               temp_valid,
  input  logic [TEMP_W-1:0]  temperature_reading,
  input  logic [TEMP_W-1:0]  temperature_setpoint,
  input  logic               manual_override,
  input  logic [SPEED_W-1:0] override_speed,
  output logic               speed_set,
  output logic [SPEED_W-1:0] current_fan_speed,
  output logic [2:0]         current_state,
  output logic               sensor_fault
);
  localparam logic [SPEED_W-1:0] MAX_SPD = '1;
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYC - 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [TEMP_W:0] HYST_V  = (TEMP_W+1)'(HYST);

  logic [TEMP_W-1:0]  sample;
  logic [TEMP_W:0]    delta, down_delta;
  logic [SPEED_W-1:0] up_target, down_target, nxt_speed;
  logic [DW_W-1:0]    dwell, nxt_dwell;
  logic [WD_W-1:0]    wd;
  logic               fault_now;
  fan_state_t         state, nxt_state;

  assign current_state = state;

  // positive error only; hysteresis widens the error seen by the downward decision,
  // except at or below setpoint where the fan is allowed to switch off
  always_comb begin
    delta      = (sample > temperature_setpoint) ? {1'b0, sample} - {1'b0, temperature_setpoint} : '0;
    down_delta = (delta == '0) ? '0 : (delta > ~HYST_V) ? '1 : delta + HYST_V;
  end

  fan_level_map #(.TEMP_W(TEMP_W), .SPEED_W(SPEED_W), .STEP(STEP)) u_up (
    .delta (delta),
    .level (up_target)
  );

  fan_level_map #(.TEMP_W(TEMP_W), .SPEED_W(SPEED_W), .STEP(STEP)) u_down (
    .delta (down_delta),
    .level (down_target)
  );

  // fault holds until the next valid reading, so a latched flag keeps it asserted
  assign fault_now = !temp_valid && (sensor_fault || wd >= WD_LAST);

  // capture valid readings and count idle cycles since the last one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample <= '0;
      wd     <= '0;
    end else begin
      sample <= temp_valid ? temperature_reading : sample;
      wd     <= temp_valid ? '0 : (wd == WD_MAX) ? wd : wd + WD_W'(1);
    end
  end

  // override beats fault beats automatic ramping; automatic steps are single levels followed by a dwell
  always_comb begin
    nxt_state = state;
    nxt_speed = current_fan_speed;
    nxt_dwell = dwell;
    if (manual_override) begin
      nxt_state = ST_OVERRIDE;
      nxt_speed = override_speed;
    end else if (fault_now) begin
      nxt_state = ST_FAULT;
      nxt_speed = MAX_SPD;
    end else if (state == ST_OVERRIDE || state == ST_FAULT) begin
      nxt_state = ST_DWELL;
      nxt_dwell = '0;
    end else if (state == ST_DWELL) begin
      nxt_state = (dwell != DW_LAST) ? ST_DWELL : (current_fan_speed == '0) ? ST_IDLE : ST_ACTIVE;
      nxt_dwell = (dwell != DW_LAST) ? dwell + DW_W'(1) : dwell;
    end else if (up_target > current_fan_speed) begin
      nxt_state = ST_DWELL;
      nxt_speed = current_fan_speed + SPEED_W'(1);
      nxt_dwell = '0;
    end else if (down_target < current_fan_speed) begin
      nxt_state = ST_DWELL;
      nxt_speed = current_fan_speed - SPEED_W'(1);
      nxt_dwell = '0;
    end
  end

  // controller state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      current_fan_speed <= '0;
      dwell             <= '0;
      speed_set         <= 1'b0;
      sensor_fault      <= 1'b0;
    end else begin
      state             <= nxt_state;
      current_fan_speed <= nxt_speed;
      dwell             <= nxt_dwell;
      speed_set         <= nxt_speed != current_fan_speed;
      sensor_fault      <= fault_now;
    end
  end
endmodule

// File: tb/tb_ramped_fan_speed_controller.sv
// tb_ramped_fan_speed_controller: scoreboard bench against a deadline-based behavioural model
module tb_ramped_fan_speed_controller;
  localparam int STEP = 5, HYST = 2, DWELL = 4, TIMEOUT = 16, MAXS = 3, MAXD = 255;
  localparam int AUTO = 0, OVR = 3, FLT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       temp_valid = 1'b0;
  logic [6:0] temperature_reading = '0;
  logic [6:0] temperature_setpoint = '0;
  logic       manual_override = 1'b0;
  logic [1:0] override_speed = '0;
  logic       speed_set;
  logic [1:0] current_fan_speed;
  logic [2:0] current_state;
  logic       sensor_fault;

  typedef struct { int cyc; int spd; int st; int flt; int set; } exp_t;
  exp_t q[$];
  int passes = 0, total = 0;
  int cyc = 0, m_speed, m_mode, m_eval, m_sample, m_last_valid;

  ramped_fan_speed_controller dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .temp_valid           (temp_valid),
    .temperature_reading  (temperature_reading),
    .temperature_setpoint (temperature_setpoint),
    .manual_override      (manual_override),
    .override_speed       (override_speed),
    .speed_set            (speed_set),
    .current_fan_speed    (current_fan_speed),
    .current_state        (current_state),
    .sensor_fault         (sensor_fault)
  );

  always #5 clk = ~clk;

  function automatic int lvl(int d);
    if (d == 0) return 0;
    return (d / STEP + 1 > MAXS) ? MAXS : d / STEP + 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_speed = 0; m_mode = AUTO; m_eval = 0; m_sample = 0; m_last_valid = cyc;
  endtask

  // one clock of stimulus: drive inputs, predict the response to the coming edge, wait for it
  task automatic tick(input bit tv, input int rd, input int sp, input bit ov, input int os);
    int delta, up, dn, old, st;
    bit flt;
    temp_valid = tv; temperature_reading = 7'(rd); temperature_setpoint = 7'(sp);
    manual_override = ov; override_speed = 2'(os);
    cyc++;
    delta = (m_sample > sp) ? m_sample - sp : 0;
    up = lvl(delta);
    dn = (delta == 0) ? 0 : lvl((delta + HYST > MAXD) ? MAXD : delta + HYST);
    flt = !tv && (cyc - m_last_valid >= TIMEOUT);
    old = m_speed;
    if (ov) begin m_speed = os; m_mode = OVR; end
    else if (flt) begin m_speed = MAXS; m_mode = FLT; end
    else if (m_mode != AUTO) begin m_mode = AUTO; m_eval = cyc + DWELL + 1; end
    else if (cyc >= m_eval && (up > m_speed || dn < m_speed)) begin
      m_speed = m_speed + ((up > m_speed) ? 1 : -1);
      m_eval = cyc + DWELL + 1;
    end
    st = (m_mode != AUTO) ? m_mode : (cyc < m_eval - 1) ? 2 : (m_speed != 0) ? 1 : 0;
    if (tv) begin m_sample = rd; m_last_valid = cyc; end
    q.push_back('{cyc, m_speed, st, int'(flt), int'(m_speed != old)});
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit tv, input int rd, input int sp, input bit ov, input int os);
    for (int i = 0; i < n; i++) tick(tv, rd, sp, ov, os);
  endtask

  // asynchronous reset mid-cycle, checked before any clock edge can act
  task automatic do_reset(string name);
    #2 reset_n = 1'b0;
    #1;
    chk({name, "_speed"}, current_fan_speed, 0);
    chk({name, "_state"}, current_state, 0);
    chk({name, "_set"}, speed_set, 0);
    chk({name, "_fault"}, sensor_fault, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // monitor: every post-reset edge presents a result that must match the next queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (current_fan_speed == 2'(e.spd) && current_state == 3'(e.st) &&
            sensor_fault == e.flt[0] && speed_set == e.set[0])
          passes++;
        else
          $display("FAIL cycle %0d: got spd=%0d st=%0d flt=%0d set=%0d, expected spd=%0d st=%0d flt=%0d set=%0d",
                   e.cyc, current_fan_speed, current_state, sensor_fault, speed_set, e.spd, e.st, e.flt, e.set);
      end
    end
  end

  initial begin
    int sp, base, rd, pv, os, n;
    bit ovs;
    @(negedge clk);
    do_reset("reset");
    run(20, 1, 80, 70, 0, 0);
    chk("ramp_up_speed", current_fan_speed, 3);
    chk("ramp_up_state", current_state, 1);
    run(20, 1, 79, 70, 0, 0);
    chk("hyst_hold_speed", current_fan_speed, 3);
    run(20, 1, 77, 70, 0, 0);
    chk("hyst_step_speed", current_fan_speed, 2);
    run(20, 1, 80, 70, 0, 0);
    chk("reramp_speed", current_fan_speed, 3);
    run(3, 1, 80, 70, 1, 1);
    chk("override_speed", current_fan_speed, 1);
    chk("override_state", current_state, 3);
    tick(1, 80, 70, 0, 0);
    chk("release_state", current_state, 2);
    run(20, 1, 80, 70, 0, 0);
    chk("release_ramp_speed", current_fan_speed, 3);
    run(20, 0, 80, 70, 0, 0);
    chk("fault_state", current_state, 4);
    chk("fault_speed", current_fan_speed, 3);
    chk("fault_flag", sensor_fault, 1);
    run(25, 1, 65, 70, 0, 0);
    chk("recover_speed", current_fan_speed, 0);
    chk("recover_state", current_state, 0);
    chk("recover_flag", sensor_fault, 0);
    run(8, 1, 80, 70, 0, 0);
    chk("mid_dwell_speed", current_fan_speed, 2);
    chk("mid_dwell_state", current_state, 2);
    do_reset("dwell_reset");
    run(12, 1, 127, 0, 0, 0);
    chk("max_error_speed", current_fan_speed, 3);
    for (int s = 0; s < 40; s++) begin
      sp = $urandom_range(50, 90);
      base = sp + int'($urandom_range(0, 40)) - 15;
      case ($urandom_range(0, 3))
        0: pv = 100;
        1: pv = 90;
        2: pv = 50;
        default: pv = 0;
      endcase
      ovs = ($urandom_range(0, 4) == 0);
      os = $urandom_range(0, 3);
      n = $urandom_range(20, 60);
      rd = base;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) rd = base + int'($urandom_range(0, 10)) - 5;
        if ($urandom_range(0, 19) == 0) sp = $urandom_range(50, 90);
        rd = (rd < 0) ? 0 : (rd > 127) ? 127 : rd;
        tick($urandom_range(0, 99) < pv, rd, sp, ovs && i < n / 2, os);
      end
      if ($urandom_range(0, 7) == 0) do_reset("rand_reset");
    end
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
